// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// control_unit : multi-cycle fetch/decode/execute sequencer and RV32I decoder
// Revision     : 1.0
// ============================================================================
module control_unit #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       sub,
  output logic       ULA_din2_sel,
  output logic [1:0] RF_din_sel,
  output logic       WE_RF,
  output logic       WE_MEM,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       pc_next_sel,
  output logic       pc_adder_sel,
  output logic       reset_ir,
  output logic       load_ir,
  output logic       halt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  // Value the wait counter holds in the last MEM cycle; unused when MEM_LATENCY is 0.
  localparam logic [2:0] c_MEM_LAST  = 3'(MEM_LATENCY - 1);

  state_t     state_q;
  logic [2:0] cnt_q;
  logic       we_rf_q;
  logic       we_mem_q;
  logic       load_pc_q;
  logic       reset_pc_q;
  logic       reset_ir_q;
  logic       load_ir_q;
  logic       halt_q;

  logic       w_is_load;
  logic       w_illegal;
  logic       w_we_rf;
  logic       w_we_mem;
  logic       w_din2;
  logic [1:0] w_rf_sel;
  logic       w_sub;
  logic       w_adder;
  logic       w_next;
  logic       w_sel_en;

  always_comb begin
    w_is_load = 1'b0;
    w_illegal = 1'b0;
    w_we_rf   = 1'b0;
    w_we_mem  = 1'b0;
    w_din2    = 1'b0;
    w_rf_sel  = 2'd0;
    w_sub     = 1'b0;
    w_adder   = 1'b0;
    w_next    = 1'b0;
    case (opcode)
      c_OP_LOAD:   begin w_is_load = 1'b1; w_din2 = 1'b1; w_adder = 1'b1; end
      c_OP_STORE:  begin w_we_mem = 1'b1; w_din2 = 1'b1; w_adder = 1'b1; end
      c_OP_OP:     begin w_we_rf = 1'b1; w_rf_sel = 2'd1; w_sub = funct7_5; w_adder = 1'b1; end
      c_OP_OPIMM:  begin w_we_rf = 1'b1; w_din2 = 1'b1; w_rf_sel = 2'd1; w_adder = 1'b1; end
      c_OP_AUIPC:  begin w_we_rf = 1'b1; w_rf_sel = 2'd3; w_adder = 1'b1; end
      c_OP_JAL:    begin w_we_rf = 1'b1; w_rf_sel = 2'd2; w_adder = 1'b1; w_next = 1'b1; end
      c_OP_JALR:   begin w_we_rf = 1'b1; w_din2 = 1'b1; w_rf_sel = 2'd2; w_next = 1'b1; end
      c_OP_BRANCH: begin
        // beq takes on zero, bne on ~zero; the comparison is a subtract in EXEC.
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          w_sub   = 1'b1;
          w_adder = 1'b1;
          w_next  = funct3[0] ? ~zero : zero;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default:     w_illegal = 1'b1;
    endcase
  end

  assign w_sel_en = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)    || (state_q == S_WB);

  assign sub          = w_sel_en & w_sub;
  assign ULA_din2_sel = w_sel_en & w_din2;
  assign RF_din_sel   = w_sel_en ? w_rf_sel : 2'd0;
  assign pc_adder_sel = w_sel_en & w_adder;
  assign pc_next_sel  = w_sel_en & w_next;

  // Strobes are registered one cycle ahead, so they follow the state they belong to.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      cnt_q      <= 3'd0;
      we_rf_q    <= 1'b0;
      we_mem_q   <= 1'b0;
      load_pc_q  <= 1'b0;
      reset_pc_q <= 1'b1;
      reset_ir_q <= 1'b1;
      load_ir_q  <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      we_rf_q    <= 1'b0;
      we_mem_q   <= 1'b0;
      load_pc_q  <= 1'b0;
      reset_pc_q <= 1'b0;
      reset_ir_q <= 1'b0;
      load_ir_q  <= 1'b0;
      case (state_q)
        S_INIT: begin
          state_q   <= S_FETCH;
          load_ir_q <= 1'b1;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (w_illegal && ILLEGAL_HALT) begin
            state_q <= S_HALT;
            halt_q  <= 1'b1;
          end else begin
            state_q <= S_EXEC;
            cnt_q   <= 3'd0;
            if (!w_is_load) begin
              we_rf_q   <= w_we_rf;
              we_mem_q  <= w_we_mem;
              load_pc_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (w_is_load) begin
            if (MEM_LATENCY == 0) begin
              state_q   <= S_WB;
              we_rf_q   <= 1'b1;
              load_pc_q <= 1'b1;
            end else begin
              state_q <= S_MEM;
            end
          end else begin
            state_q   <= S_FETCH;
            load_ir_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (cnt_q == c_MEM_LAST) begin
            state_q   <= S_WB;
            we_rf_q   <= 1'b1;
            load_pc_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          load_ir_q <= 1'b1;
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q    <= S_INIT;
          reset_pc_q <= 1'b1;
          reset_ir_q <= 1'b1;
        end
      endcase
    end
  end

  assign WE_RF    = we_rf_q;
  assign WE_MEM   = we_mem_q;
  assign load_pc  = load_pc_q;
  assign reset_pc = reset_pc_q;
  assign reset_ir = reset_ir_q;
  assign load_ir  = load_ir_q;
  assign halt     = halt_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// tb_control_unit : randomized instruction stream scored against a table model,
// plus directed reset-abort, zero-latency load and HALT sequences.
module tb_control_unit;

  localparam int unsigned ML1     = 2;
  localparam int          N_INSTR = 80;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // u1: MEM_LATENCY=2, illegal -> NOP ; u2: MEM_LATENCY=0, illegal -> HALT
  logic       rst1_n, f7_1, z1;
  logic [6:0] op1;
  logic [2:0] f3_1;
  logic       sub1, din2_1, we_rf1, we_mem1, lpc1, rpc1, next1, adder1, rir1, lir1, halt1;
  logic [1:0] rf1;
  logic [2:0] st1;

  logic       rst2_n, f7_2, z2;
  logic [6:0] op2;
  logic [2:0] f3_2;
  logic       sub2, din2_2, we_rf2, we_mem2, lpc2, rpc2, next2, adder2, rir2, lir2, halt2;
  logic [1:0] rf2;
  logic [2:0] st2;

  control_unit #(.MEM_LATENCY(ML1), .ILLEGAL_HALT(1'b0)) u1 (
    .CLK(CLK), .reset_n(rst1_n), .opcode(op1), .funct3(f3_1), .funct7_5(f7_1), .zero(z1),
    .sub(sub1), .ULA_din2_sel(din2_1), .RF_din_sel(rf1), .WE_RF(we_rf1), .WE_MEM(we_mem1),
    .load_pc(lpc1), .reset_pc(rpc1), .pc_next_sel(next1), .pc_adder_sel(adder1),
    .reset_ir(rir1), .load_ir(lir1), .halt(halt1), .state(st1)
  );

  control_unit #(.MEM_LATENCY(0), .ILLEGAL_HALT(1'b1)) u2 (
    .CLK(CLK), .reset_n(rst2_n), .opcode(op2), .funct3(f3_2), .funct7_5(f7_2), .zero(z2),
    .sub(sub2), .ULA_din2_sel(din2_2), .RF_din_sel(rf2), .WE_RF(we_rf2), .WE_MEM(we_mem2),
    .load_pc(lpc2), .reset_pc(rpc2), .pc_next_sel(next2), .pc_adder_sel(adder2),
    .reset_ir(rir2), .load_ir(lir2), .halt(halt2), .state(st2)
  );

  typedef struct packed {
    logic [3:0] cycles;
    logic [2:0] fstate;
    logic       we_rf;
    logic       we_mem;
    logic [1:0] rf;
    logic       sub;
    logic       din2;
    logic       adder;
    logic       next;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  bit   mon_en  = 1'b0;
  int   cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural expectation for one instruction on u1 (illegal executes as PC+4).
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic z);
    exp_t e;
    e = '0;
    e.cycles = 4'd3;
    e.fstate = 3'd3;
    case (op)
      7'b0000011: begin e.din2 = 1; e.adder = 1; e.we_rf = 1;
                        e.cycles = 4'(4 + ML1); e.fstate = 3'd5; end
      7'b0100011: begin e.din2 = 1; e.adder = 1; e.we_mem = 1; end
      7'b0110011: begin e.rf = 2'd1; e.sub = f7; e.adder = 1; e.we_rf = 1; end
      7'b0010011: begin e.din2 = 1; e.rf = 2'd1; e.adder = 1; e.we_rf = 1; end
      7'b0010111: begin e.rf = 2'd3; e.adder = 1; e.we_rf = 1; end
      7'b1101111: begin e.rf = 2'd2; e.adder = 1; e.next = 1; e.we_rf = 1; end
      7'b1100111: begin e.din2 = 1; e.rf = 2'd2; e.next = 1; e.we_rf = 1; end
      7'b1100011: if (f3 == 3'd0 || f3 == 3'd1) begin
                    e.sub = 1; e.adder = 1;
                    e.next = (f3 == 3'd0) ? z : ~z;
                  end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: each load_pc pulse completes one instruction and retires one expectation.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (lir1) begin
        cyc = 1;
        chk("fetch_state", st1, 3'd1);
        chk("fetch_sels_zero", {sub1, din2_1, rf1, next1, adder1}, 6'd0);
      end else begin
        cyc = cyc + 1;
      end
      if (lpc1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_load_pc: got load_pc=1 in state %0d, expected no pending instruction", st1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("instr_cycles", cyc, e.cycles);
          chk("final_state", st1, e.fstate);
          chk("final_strobes", {we_rf1, we_mem1, halt1}, {e.we_rf, e.we_mem, 1'b0});
          chk("final_sels", {rf1, sub1, din2_1, adder1, next1},
              {e.rf, e.sub, e.din2, e.adder, e.next});
        end
      end else begin
        chk("no_strobe_midinstr", {we_rf1, we_mem1}, 2'd0);
      end
    end
  end

  logic [6:0] ops [0:8];
  logic [6:0] dir_op [0:12];
  logic [2:0] dir_f3 [0:12];
  logic       dir_f7 [0:12];
  logic       dir_z  [0:12];

  initial begin
    int  t;
    bit  found;
    int  k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111};
    // add, sub, ld, beq z=1, beq z=0, bne, jal, jalr, sw, addi, auipc, lui, branch f3=2
    dir_op = '{7'b0110011, 7'b0110011, 7'b0000011, 7'b1100011, 7'b1100011, 7'b1100011,
               7'b1101111, 7'b1100111, 7'b0100011, 7'b0010011, 7'b0010111, 7'b0110111,
               7'b1100011};
    dir_f3 = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd2};
    dir_f7 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dir_z  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst1_n = 1'b0; op1 = '0; f3_1 = '0; f7_1 = 1'b0; z1 = 1'b0;
    rst2_n = 1'b0; op2 = '0; f3_2 = '0; f7_2 = 1'b0; z2 = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_state", st1, 3'd0);
    chk("rst_strobes", {we_rf1, we_mem1, lpc1, lir1, halt1}, 5'd0);
    chk("rst_clears", {rpc1, rir1}, 2'b11);
    chk("rst_sels", {sub1, din2_1, rf1, next1, adder1}, 6'd0);

    rst1_n = 1'b1;
    #1;
    chk("init_state", {st1, rpc1, rir1}, {3'd0, 2'b11});
    @(posedge CLK); #1;
    chk("init_to_fetch", {st1, lir1, rpc1, rir1}, {3'd1, 1'b1, 2'b00});

    // add, then pull reset in the middle of its EXEC cycle
    op1 = 7'b0110011; f3_1 = 3'd0; f7_1 = 1'b0; z1 = 1'b0;
    @(posedge CLK); #1;
    chk("add_decode", {st1, we_rf1, lpc1, rf1}, {3'd2, 1'b0, 1'b0, 2'd1});
    @(posedge CLK); #1;
    chk("add_exec", {st1, we_rf1, lpc1, rf1, sub1}, {3'd3, 1'b1, 1'b1, 2'd1, 1'b0});
    rst1_n = 1'b0;
    #1;
    chk("abort_exec", {st1, we_rf1, lpc1, rpc1, rir1}, {3'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge CLK);
    rst1_n = 1'b1;
    @(posedge CLK); #1;
    chk("abort_refetch", {st1, lir1}, {3'd1, 1'b1});

    mon_en = 1'b1;
    for (int n = 0; n < N_INSTR; n++) begin
      t = 0;
      while (!lir1 && t < 20) begin
        @(posedge CLK); #1;
        t++;
      end
      chk("fetch_reached", lir1, 1'b1);
      if (!lir1) break;
      if (n < 13) begin
        op1 = dir_op[n]; f3_1 = dir_f3[n]; f7_1 = dir_f7[n]; z1 = dir_z[n];
      end else begin
        k = $urandom_range(0, 9);
        op1  = (k == 9) ? 7'($urandom) : ops[k];
        f3_1 = (op1 == 7'b1100011) ? 3'($urandom_range(0, 2)) : 3'($urandom);
        f7_1 = 1'($urandom);
        z1   = 1'($urandom);
      end
      q.push_back(model(op1, f3_1, f7_1, z1));
      @(posedge CLK); #1;
    end
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    chk("scoreboard_drained", q.size(), 0);
    mon_en = 1'b0;

    // u2: zero-latency load then an unsupported opcode that must halt
    op2 = 7'b0000011; f3_2 = 3'd2;
    @(negedge CLK);
    chk("u2_rst", {st2, halt2, rpc2, rir2}, {3'd0, 1'b0, 2'b11});
    rst2_n = 1'b1;
    @(posedge CLK); #1;
    chk("u2_fetch", {st2, lir2}, {3'd1, 1'b1});
    found = 1'b0;
    for (int c = 2; c <= 8 && !found; c++) begin
      @(posedge CLK); #1;
      if (lpc2) begin
        found = 1'b1;
        chk("ml0_load_len", c, 4);
        chk("ml0_load_wb", {st2, we_rf2, we_mem2, rf2}, {3'd5, 1'b1, 1'b0, 2'd0});
      end else begin
        chk("ml0_load_nostrobe", {we_rf2, we_mem2}, 2'd0);
      end
    end
    chk("ml0_load_seen", found, 1'b1);
    @(posedge CLK); #1;
    chk("u2_refetch", {st2, lir2}, {3'd1, 1'b1});
    op2 = 7'b0110111;
    @(posedge CLK); #1;
    chk("lui_decode", {st2, halt2}, {3'd2, 1'b0});
    @(posedge CLK); #1;
    chk("lui_halt", {st2, halt2}, {3'd7, 1'b1});
    repeat (10) begin
      @(posedge CLK); #1;
      chk("halt_hold", {st2, halt2, we_rf2, we_mem2, lpc2, lir2},
          {3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    rst2_n = 1'b0;
    #1;
    chk("halt_cleared", {st2, halt2, rpc2}, {3'd0, 1'b0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
